data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised single-port data memory with a valid/ready request interface, byte-enable writes, a configurable read latency with back-pressure, and a post-reset initialisation sweep. It sits between the CPU load/store stage and the data array and replaces the fixed 256×32 asynchronous-read memory. Every accepted request, read or write, returns exactly one in-order response carrying read data and an error flag.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, at least 8.
- DEPTH, 256: number of words; power of two.
- RD_LAT, 1: request-accept to response-valid latency in cycles; legal values 1 to 4.
- INIT_VAL, 12: value written to every word by the init sweep.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_be  in  DATA_W/8  byte enables; ignored for reads.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored reads.
- rsp_err  out  1  request was misaligned or out of range.
- init_done  out  1  high once the init sweep has completed.

## Operation
- Derived constants: BE_W = DATA_W/8, OFS_W = log2(BE_W), IDX_W = log2(DEPTH).
- Word index = req_addr[OFS_W +: IDX_W].
- Misaligned when req_addr[OFS_W-1:0] != 0. Out of range when req_addr[31:OFS_W+IDX_W] != 0. err = misaligned || out of range.
- FSM states:
  - INIT: entered on reset. A counter walks indices 0 to DEPTH-1 and writes INIT_VAL, one word per cycle. req_ready = 0 and init_done = 0.
  - RUN: entered after index DEPTH-1 is written. init_done = 1. Stays in RUN until the next reset.
- Accepted write without err: for each byte b with req_be[b] = 1, write byte b at the accept edge. Other bytes are unchanged. The response has rdata = 0 and err = 0.
- Accepted write with err: the array is unchanged. The response has err = 1 and rdata = 0.
- Accepted read: the array is sampled at the accept edge. The response carries that data, or 0 with err = 1 when err applies.
- Response pipeline: RD_LAT stages, each holding valid, rdata and err.
  - The pipeline advances when the output stage is empty or rsp_ready = 1.
  - When the pipeline is stalled, its contents hold and req_ready = 0.
- req_ready = (state == RUN) && !stall, where stall = rsp_valid && !rsp_ready. This rule keeps at most RD_LAT requests outstanding with no overflow.
- Ordering is strictly in order. A read accepted in the cycle after a write to the same word returns the new data. Only one request is accepted per cycle, so no same-cycle hazard exists.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0, all pipeline valids = 0. The array contents are not reset directly; the sweep rewrites them.
- Init takes DEPTH cycles after rst_n rises. init_done and req_ready first go high in cycle DEPTH+1 after reset release.
- A request accepted at edge N produces rsp_valid at edge N+RD_LAT when there are no stalls. Each stall cycle adds one cycle.
- Full throughput is one request per cycle while rsp_ready = 1.
- rsp_rdata and rsp_err stay stable while rsp_valid && !rsp_ready.
- Reset asserted mid-operation: in-flight responses are discarded, the FSM returns to INIT, and the sweep restarts. Any write accepted in the reset cycle is dropped.
- Outputs are registered. No combinational path exists from req_* to rsp_*. req_ready depends combinationally only on rsp_ready and state.

## Structure
- Package data_mem_pkg holds:
  - the state enum (INIT, RUN);
  - the function computing err from addr, DATA_W and DEPTH;
  - the default parameter constants.
- Sub-module data_mem_rsp_pipe: a parametrised (RD_LAT, DATA_W+1) stall-able valid/data shift pipeline. The top level holds the array, the FSM, the sweep counter and the decode logic.

## Test plan
- Reset, then wait: init_done rises after exactly 256 cycles. A read of addr 0x3FC returns 12 with err = 0.
- Write 0xDEADBEEF to 0x10 with be = 4'b1111, then be = 4'b0010 with 0x0000AA00, then read 0x10: returns 0xDEADAAEF.
- Read addr 0x11 returns err = 1, rdata = 0. Write to 0x400 returns err = 1, and a following read of 0x0 still returns 12.
- RD_LAT = 3: issue 8 back-to-back reads with rsp_ready held low for 5 cycles mid-stream. Responses arrive in order with none lost or duplicated, and req_ready is low exactly during the stall.
- Write then immediate read of the same word in consecutive cycles: the read returns the new data.
- Assert rst_n = 0 with 2 reads in flight: rsp_valid drops next cycle, the sweep restarts, and the memory reads INIT_VAL after init_done.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types, defaults and address check for data_mem_ctrl
package data_mem_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 256;
    localparam int unsigned DEF_RD_LAT   = 1;
    localparam int unsigned DEF_INIT_VAL = 12;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A request errors when it is not word aligned or lies past the last word.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned data_w,
        input int unsigned depth
    );
        logic [31:0] ofs_mask;
        logic [63:0] span;
        ofs_mask = 32'(data_w / 8) - 32'd1;
        span     = 64'(data_w / 8) * 64'(depth);
        return ((addr & ofs_mask) != 32'd0) || ({32'd0, addr} >= span);
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - request/response bus between load/store stage and data_mem_ctrl
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_W/8-1:0]   req_be;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

endinterface

// File: rtl/data_mem_rsp_pipe.sv
// rtl/data_mem_rsp_pipe.sv - stall-able valid/data shift pipeline for memory responses
module data_mem_rsp_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned STAGES = DEF_RD_LAT,
    parameter int unsigned WIDTH  = DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic              advance;

    // The whole pipe moves together; it only freezes when the head is full and not taken.
    assign advance   = !vld[STAGES-1] || out_ready;
    assign out_valid = vld[STAGES-1];
    assign out_data  = dat[STAGES-1];

    // Shift entries toward the output; bubbles carry zero data so idle outputs read as 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                dat[i] <= '0;
            end
        end else if (advance) begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-port data memory with init sweep and in-order responses
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned INIT_VAL = DEF_INIT_VAL
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(BE_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PIPE_W = DATA_W + 1;

    state_t              state;
    logic [IDX_W-1:0]    sweep_idx;
    logic                init_done_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                stall;
    logic                accept;
    logic                req_err;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rsp_word;
    logic [PIPE_W-1:0]   pipe_in;
    logic [PIPE_W-1:0]   pipe_out;
    logic                pipe_out_valid;

    // Back-pressure only ever comes from an unconsumed head response.
    assign stall         = pipe_out_valid && !bus.rsp_ready;
    assign bus.req_ready = (state == ST_RUN) && !stall;
    assign accept        = bus.req_valid && bus.req_ready;

    assign req_err  = addr_err(bus.req_addr, DATA_W, DEPTH);
    assign idx      = bus.req_addr[OFS_W +: IDX_W];
    assign rd_word  = mem[idx];
    assign rsp_word = (bus.req_we || req_err) ? '0 : rd_word;
    assign pipe_in  = {req_err, rsp_word};

    // Init sweep walks every index once after reset, then the controller serves requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sweep_idx   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == IDX_W'(DEPTH - 1)) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Array write port: sweep fill, or byte-enabled store; nothing lands during reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem[sweep_idx] <= DATA_W'(INIT_VAL);
            end else if (accept && bus.req_we && !req_err) begin
                for (int b = 0; b < int'(BE_W); b++) begin
                    if (bus.req_be[b]) begin
                        mem[idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    data_mem_rsp_pipe #(
        .STAGES (RD_LAT),
        .WIDTH  (PIPE_W)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_data   (pipe_in),
        .out_ready (bus.rsp_ready),
        .out_valid (pipe_out_valid),
        .out_data  (pipe_out)
    );

    assign bus.rsp_valid = pipe_out_valid;
    assign bus.rsp_err   = pipe_out[PIPE_W-1];
    assign bus.rsp_rdata = pipe_out[DATA_W-1:0];
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned RD_LAT   = 3;
    localparam int unsigned INIT_VAL = 12;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;

    data_mem_if #(.DATA_W(DATA_W)) bus ();

    data_mem_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RD_LAT   (RD_LAT),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    rsp_t        exp_q [$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;
    bit          rand_rsp = 1'b0;
    bit          hold_pending = 1'b0;
    logic [33:0] hold_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted request, straight from the address/byte rules.
    task automatic model_accept(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wd);
        rsp_t e;
        int   w;
        e.err = ((addr % 4) != 0) || (addr >= DEPTH * 4);
        w     = int'((addr / 4) % DEPTH);
        if (we) begin
            if (!e.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mdl[w][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
            e.rdata = 32'd0;
        end else begin
            e.rdata = e.err ? 32'd0 : mdl[w];
        end
        exp_q.push_back(e);
    endtask

    // One clock: observe handshakes mid-cycle, then advance past the rising edge.
    task automatic step_cycle(output bit acc, output bit got, output bit rdy);
        rsp_t e;
        @(negedge clk);
        rdy = bus.req_ready;
        acc = bus.req_valid && bus.req_ready;
        got = bus.rsp_valid && bus.rsp_ready;
        if (hold_pending) chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, hold_val);
        hold_pending = bus.rsp_valid && !bus.rsp_ready;
        hold_val     = {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
        if (got) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", bus.rsp_err, e.err);
            end
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
        end
        if (acc) model_accept(bus.req_we, bus.req_addr, bus.req_be, bus.req_wdata);
        @(posedge clk);
        #1;
        if (rand_rsp) bus.rsp_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        bit acc, got, rdy;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wd;
        while (!acc && n < 200) begin
            step_cycle(acc, got, rdy);
            n++;
        end
        if (!acc) chk("req_accept_timeout", 64'(acc), 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bit a, g, r;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step_cycle(a, g, r);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'(INIT_VAL);
        exp_q.delete();
        hold_pending = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_cycles", 64'(n), 64'(DEPTH));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a, g, r;
        int          n, i, cyc;
        logic        we;
        logic [7:0]  ridx;
        logic [31:0] addr;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_be    = 4'd0;
        bus.req_wdata = 32'd0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_init_done", bus.init_done, 1'b0);

        do_reset();

        // First read after init, with latency measured from the accept edge.
        issue(1'b0, 32'h3FC, 4'h0, 32'd0);
        n = 0;
        g = 1'b0;
        while (!g && n < 20) begin
            step_cycle(a, g, r);
            n++;
        end
        chk("rd_latency", 64'(n), 64'(RD_LAT));
        chk("init_rdata", last_rdata, 32'd12);
        chk("init_err", last_err, 1'b0);

        // Byte-enable merge.
        issue(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        issue(1'b1, 32'h10, 4'b0010, 32'h0000AA00);
        issue(1'b0, 32'h10, 4'h0, 32'd0);
        drain();
        chk("be_merge", last_rdata, 32'hDEADAAEF);

        // Error cases.
        issue(1'b0, 32'h11, 4'h0, 32'd0);
        drain();
        chk("mis_err", last_err, 1'b1);
        chk("mis_rdata", last_rdata, 32'd0);
        issue(1'b1, 32'h400, 4'hF, 32'h12345678);
        drain();
        chk("oor_err", last_err, 1'b1);
        chk("oor_rdata", last_rdata, 32'd0);
        issue(1'b0, 32'h0, 4'h0, 32'd0);
        drain();
        chk("oor_nowrite", last_rdata, 32'd12);

        // Write immediately followed by a read of the same word.
        issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
        issue(1'b0, 32'h20, 4'h0, 32'd0);
        drain();
        chk("raw_rdata", last_rdata, 32'hCAFEF00D);

        // Eight back-to-back reads with the consumer stalled for five cycles.
        for (int k = 0; k < 8; k++) issue(1'b1, 32'(32'h100 + k * 4), 4'hF, 32'(k * 32'h11111111 + 1));
        drain();
        i   = 0;
        cyc = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h100;
        while (i < 8 && cyc < 60) begin
            bus.rsp_ready = !(cyc >= 5 && cyc < 10);
            step_cycle(a, g, r);
            if (cyc <= 10) chk("stall_req_ready", r, !(cyc >= 5 && cyc < 10));
            if (a) begin
                i++;
                if (i < 8) bus.req_addr = 32'(32'h100 + i * 4);
                else bus.req_valid = 1'b0;
            end
            cyc++;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        chk("stall_accepts", 64'(i), 64'd8);
        drain();

        // Randomised traffic with random consumer back-pressure.
        rand_rsp = 1'b1;
        for (int k = 0; k < 300; k++) begin
            n    = $urandom_range(0, 9);
            ridx = 8'($urandom_range(0, 255));
            if (n < 8) addr = {22'd0, ridx, 2'b00};
            else if (n == 8) addr = {22'd0, ridx, 2'($urandom_range(1, 3))};
            else addr = $urandom | 32'h0000_0400;
            we = 1'($urandom_range(0, 1));
            issue(we, addr, 4'($urandom), $urandom);
            if ($urandom_range(0, 4) == 0) step_cycle(a, g, r);
        end
        drain();
        rand_rsp = 1'b0;
        bus.rsp_ready = 1'b1;

        // Reset with two reads in flight and a write offered in the reset cycle.
        issue(1'b0, 32'h10, 4'h0, 32'd0);
        issue(1'b0, 32'h14, 4'h0, 32'd0);
        step_cycle(a, g, r);
        chk("pre_rst_valid", bus.rsp_valid, 1'b1);
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_be    = 4'hF;
        bus.req_wdata = 32'h55555555;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", bus.rsp_valid, 1'b0);
        chk("rst_mid_init", bus.init_done, 1'b0);
        chk("rst_mid_ready", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        do_reset();
        issue(1'b0, 32'h0, 4'h0, 32'd0);
        issue(1'b0, 32'h40, 4'h0, 32'd0);
        drain();
        chk("post_rst_drop", last_rdata, 32'd12);
        issue(1'b0, 32'h10, 4'h0, 32'd0);
        drain();
        chk("post_rst_sweep", last_rdata, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
